// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures execute results and control, resolves the redirect.
// Optional perf counters are built only when EXMEM_PERF_CNT_EN is defined.
module ex_mem_reg #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_ex,
  input  logic [XLEN-1:0] pc_target_ex,
  input  logic [XLEN-1:0] pc4_ex,
  input  logic            zero_ex,
  input  logic [XLEN-1:0] alu_ex,
  input  logic [XLEN-1:0] rs2_ex,
  input  logic [RD_W-1:0] rd_ex,
  input  logic            reg_write_ex,
  input  logic            mem_read_ex,
  input  logic            mem_write_ex,
  input  logic            branch_ex,
  input  logic            jump_ex,
  input  logic [1:0]      mem_to_reg_ex,
  output logic            valid_mem,
  output logic [XLEN-1:0] pc_target_mem,
  output logic [XLEN-1:0] pc4_mem,
  output logic            zero_mem,
  output logic [XLEN-1:0] alu_mem,
  output logic [XLEN-1:0] rs2_mem,
  output logic [RD_W-1:0] rd_mem,
  output logic            reg_write_mem,
  output logic            mem_read_mem,
  output logic            mem_write_mem,
  output logic [1:0]      mem_to_reg_mem,
  output logic            pc_src_mem,
  output logic [31:0]     perf_retired_o,
  output logic [31:0]     perf_bubble_o
);

  logic branch_mem;
  logic jump_mem;
  logic load;

  assign load = !flush_i && !stall_i;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      valid_mem      <= 1'b0;
      pc_target_mem  <= '0;
      pc4_mem        <= '0;
      zero_mem       <= 1'b0;
      alu_mem        <= '0;
      rs2_mem        <= '0;
      rd_mem         <= '0;
      reg_write_mem  <= 1'b0;
      mem_read_mem   <= 1'b0;
      mem_write_mem  <= 1'b0;
      branch_mem     <= 1'b0;
      jump_mem       <= 1'b0;
      mem_to_reg_mem <= 2'b00;
    end else if (load) begin
      valid_mem      <= valid_ex;
      pc_target_mem  <= pc_target_ex;
      pc4_mem        <= pc4_ex;
      zero_mem       <= zero_ex;
      alu_mem        <= alu_ex;
      rs2_mem        <= rs2_ex;
      rd_mem         <= rd_ex;
      // Invalid slots must not have side effects downstream; data is kept for debug visibility.
      reg_write_mem  <= valid_ex & reg_write_ex;
      mem_read_mem   <= valid_ex & mem_read_ex;
      mem_write_mem  <= valid_ex & mem_write_ex;
      branch_mem     <= valid_ex & branch_ex;
      jump_mem       <= valid_ex & jump_ex;
      mem_to_reg_mem <= mem_to_reg_ex;
    end
  end

  // Redirect derives only from registered state so fetch never sees an EX-stage path.
  assign pc_src_mem = valid_mem & ((branch_mem & zero_mem) | jump_mem);

`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      bubble_cnt  <= '0;
    end else if (flush_i) begin
      bubble_cnt  <= bubble_cnt + 32'd1;
    end else if (!stall_i) begin
      if (valid_ex) retired_cnt <= retired_cnt + 32'd1;
      else          bubble_cnt  <= bubble_cnt + 32'd1;
    end
  end

  assign perf_retired_o = retired_cnt;
  assign perf_bubble_o  = bubble_cnt;
`else
  assign perf_retired_o = 32'd0;
  assign perf_bubble_o  = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: a reference model pushes the expected MEM-side state
// per edge, which is popped and compared one cycle later.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst_n, stall_i, flush_i, valid_ex, zero_ex;
  logic [31:0] pc_target_ex, pc4_ex, alu_ex, rs2_ex;
  logic [4:0]  rd_ex;
  logic        reg_write_ex, mem_read_ex, mem_write_ex, branch_ex, jump_ex;
  logic [1:0]  mem_to_reg_ex;
  logic        valid_mem, zero_mem, reg_write_mem, mem_read_mem, mem_write_mem, pc_src_mem;
  logic [31:0] pc_target_mem, pc4_mem, alu_mem, rs2_mem, perf_retired_o, perf_bubble_o;
  logic [4:0]  rd_mem;
  logic [1:0]  mem_to_reg_mem;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        valid, zero, rw, mr, mw, br, jp;
    logic [31:0] tgt, pc4, alu, rs2, ret, bub;
    logic [4:0]  rd;
    logic [1:0]  m2r;
  } exp_t;

  exp_t mdl;
  exp_t sb[$];

  always #5 clk = ~clk;

  ex_mem_reg #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .valid_ex(valid_ex), .pc_target_ex(pc_target_ex), .pc4_ex(pc4_ex),
    .zero_ex(zero_ex), .alu_ex(alu_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
    .mem_write_ex(mem_write_ex), .branch_ex(branch_ex), .jump_ex(jump_ex),
    .mem_to_reg_ex(mem_to_reg_ex), .valid_mem(valid_mem),
    .pc_target_mem(pc_target_mem), .pc4_mem(pc4_mem), .zero_mem(zero_mem),
    .alu_mem(alu_mem), .rs2_mem(rs2_mem), .rd_mem(rd_mem),
    .reg_write_mem(reg_write_mem), .mem_read_mem(mem_read_mem),
    .mem_write_mem(mem_write_mem), .mem_to_reg_mem(mem_to_reg_mem),
    .pc_src_mem(pc_src_mem), .perf_retired_o(perf_retired_o),
    .perf_bubble_o(perf_bubble_o)
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_in();
    valid_ex = 0; zero_ex = 0; pc_target_ex = 0; pc4_ex = 0; alu_ex = 0; rs2_ex = 0;
    rd_ex = 0; reg_write_ex = 0; mem_read_ex = 0; mem_write_ex = 0;
    branch_ex = 0; jump_ex = 0; mem_to_reg_ex = 0; stall_i = 0; flush_i = 0;
  endtask

  // Drive current inputs across one rising edge and check the resulting state.
  task automatic step();
    exp_t n, e;
    logic pcs;
    n = mdl;
    if (!rst_n || flush_i) begin
      n.valid = 0; n.zero = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.br = 0; n.jp = 0;
      n.tgt = 0; n.pc4 = 0; n.alu = 0; n.rs2 = 0; n.rd = 0; n.m2r = 0;
      if (!rst_n) begin n.ret = 0; n.bub = 0; end
      else n.bub = mdl.bub + 1;
    end else if (!stall_i) begin
      n.valid = valid_ex; n.zero = zero_ex; n.tgt = pc_target_ex; n.pc4 = pc4_ex;
      n.alu = alu_ex; n.rs2 = rs2_ex; n.rd = rd_ex; n.m2r = mem_to_reg_ex;
      n.rw = valid_ex & reg_write_ex; n.mr = valid_ex & mem_read_ex;
      n.mw = valid_ex & mem_write_ex; n.br = valid_ex & branch_ex;
      n.jp = valid_ex & jump_ex;
      if (valid_ex) n.ret = mdl.ret + 1; else n.bub = mdl.bub + 1;
    end
    mdl = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    pcs = e.valid & ((e.br & e.zero) | e.jp);
    chk_val("valid", 32'(valid_mem), 32'(e.valid));
    chk_val("pc_target", pc_target_mem, e.tgt);
    chk_val("pc4", pc4_mem, e.pc4);
    chk_val("zero", 32'(zero_mem), 32'(e.zero));
    chk_val("alu", alu_mem, e.alu);
    chk_val("rs2", rs2_mem, e.rs2);
    chk_val("rd", 32'(rd_mem), 32'(e.rd));
    chk_val("reg_write", 32'(reg_write_mem), 32'(e.rw));
    chk_val("mem_read", 32'(mem_read_mem), 32'(e.mr));
    chk_val("mem_write", 32'(mem_write_mem), 32'(e.mw));
    chk_val("mem_to_reg", 32'(mem_to_reg_mem), 32'(e.m2r));
    chk_val("pc_src", 32'(pc_src_mem), 32'(pcs));
`ifdef EXMEM_PERF_CNT_EN
    chk_val("perf_retired", perf_retired_o, e.ret);
    chk_val("perf_bubble", perf_bubble_o, e.bub);
`else
    chk_val("perf_retired", perf_retired_o, 32'd0);
    chk_val("perf_bubble", perf_bubble_o, 32'd0);
`endif
  endtask

  initial begin
    mdl = '{default: '0};
    // Reset held with busy inputs.
    clear_in();
    rst_n = 0; valid_ex = 1; alu_ex = 32'hFFFF_FFFF; rs2_ex = 32'h5555_5555;
    pc_target_ex = 32'h40; rd_ex = 5'd31; reg_write_ex = 1; jump_ex = 1; zero_ex = 1;
    mem_to_reg_ex = 2'b10; stall_i = 1;
    step(); step();
    rst_n = 1;

    // Plain load.
    clear_in();
    valid_ex = 1; alu_ex = 32'h0000_1234; rs2_ex = 32'hDEAD_BEEF; rd_ex = 5'd5;
    reg_write_ex = 1; pc4_ex = 32'h104; mem_to_reg_ex = 2'b01;
    step();

    // Branch taken, not taken, jump.
    clear_in();
    valid_ex = 1; branch_ex = 1; zero_ex = 1; pc_target_ex = 32'h40;
    step();
    zero_ex = 0; step();
    branch_ex = 0; jump_ex = 1; zero_ex = 0; step();

    // Stall holds everything, release captures current input.
    clear_in();
    valid_ex = 1; alu_ex = 32'hA; step();
    stall_i = 1; alu_ex = 32'hB;
    repeat (3) step();
    stall_i = 0; step();

    // Flush beats stall.
    clear_in();
    stall_i = 1; flush_i = 1; valid_ex = 1; mem_write_ex = 1; alu_ex = 32'h77;
    step();

    // Invalid slot: control suppressed, data captured.
    clear_in();
    valid_ex = 0; reg_write_ex = 1; jump_ex = 1; alu_ex = 32'hCAFE; step();

    // x0 destination passes through.
    clear_in();
    valid_ex = 1; rd_ex = 5'd0; reg_write_ex = 1; mem_read_ex = 1; step();

    // Random traffic with occasional stall, flush and reset.
    for (int i = 0; i < 60; i++) begin
      rst_n = ($urandom_range(0, 19) != 0);
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 5) == 0);
      valid_ex = $urandom_range(0, 1);
      zero_ex = $urandom_range(0, 1);
      pc_target_ex = $urandom; pc4_ex = $urandom; alu_ex = $urandom; rs2_ex = $urandom;
      rd_ex = 5'($urandom); mem_to_reg_ex = 2'($urandom);
      reg_write_ex = $urandom_range(0, 1); mem_read_ex = $urandom_range(0, 1);
      mem_write_ex = $urandom_range(0, 1); branch_ex = $urandom_range(0, 1);
      jump_ex = $urandom_range(0, 1);
      step();
    end

    // Reset during stall and flush.
    rst_n = 1; clear_in(); valid_ex = 1; alu_ex = 32'h5; step();
    rst_n = 0; stall_i = 1; flush_i = 1; step();
    rst_n = 1; clear_in();

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline register for the five-stage RV32 pipeline. Captures the execute-stage results (ALU result, store data, branch target, PC+4, zero flag) together with the control bundle and destination register, and presents them to the MEM stage one cycle later. Supports stall (hold) and flush (bubble insertion), and resolves the registered branch/jump decision (`pc_src_mem`) used by the fetch stage to redirect.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `RD_W`, 5, register-index width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `stall_i`  in  1  hold all registers
- `flush_i`  in  1  load a bubble
- `valid_ex`  in  1  EX-stage instruction is valid
- `pc_target_ex`  in  XLEN  branch/jump target (PC+imm)
- `pc4_ex`  in  XLEN  PC+4
- `zero_ex`  in  1  ALU zero flag
- `alu_ex`  in  XLEN  ALU result
- `rs2_ex`  in  XLEN  store data
- `rd_ex`  in  RD_W  destination register
- `reg_write_ex`, `mem_read_ex`, `mem_write_ex`, `branch_ex`, `jump_ex`  in  1 each  control bits
- `mem_to_reg_ex`  in  2  writeback source select (00 ALU, 01 memory, 10 PC+4)
- `valid_mem`, `pc_target_mem`, `pc4_mem`, `zero_mem`, `alu_mem`, `rs2_mem`, `rd_mem`, `reg_write_mem`, `mem_read_mem`, `mem_write_mem`, `mem_to_reg_mem`  out  same widths  registered copies
- `pc_src_mem`  out  1  redirect request: `valid_mem & ((branch_mem & zero_mem) | jump_mem)`
- `perf_retired_o`  out  32  count of valid instructions captured
- `perf_bubble_o`  out  32  count of bubbles captured

## Operation
- Each rising edge, priority: reset > flush > stall > load.
- Reset (`rst_n`=0): every registered output to 0 (including `valid_mem`, all control bits, data fields, both perf counters).
- Flush: all registered fields to 0; `valid_mem`=0. Flush overrides stall in the same cycle.
- Stall (no flush): all registers, counters included, hold their value.
- Load: every `*_ex` input copied to its `*_mem` output. If `valid_ex`=0, control bits (`reg_write`, `mem_read`, `mem_write`, `branch`, `jump`) are stored as 0 regardless of input; data fields are still captured.
- `pc_src_mem` is combinational from registered state only (no path from `*_ex` inputs); it is 0 whenever `valid_mem`=0.
- `rd_mem`=0 with `reg_write_mem`=1 is passed through unchanged; x0 suppression belongs to the register file.
- Perf counters (see Configuration) advance only on load cycles: `valid_ex`=1 increments `perf_retired_o`, else `perf_bubble_o`. A flush cycle increments `perf_bubble_o`. Counters wrap modulo 2^32.

## Timing
- Latency: 1 cycle from `*_ex` to `*_mem`.
- `pc_src_mem` and `pc_target_mem` valid in the cycle after the branch was in EX. The hazard unit asserts `flush_i` for the younger instruction in that cycle.
- Stall released: the value present on `*_ex` in the first non-stalled cycle is captured at that edge.
- Reset asserted mid-stall or mid-flush: reset wins; outputs are 0 after the edge.

## Configuration
- `EXMEM_PERF_CNT_EN`: when defined, the two 32-bit counters are implemented as described. When undefined, `perf_retired_o` and `perf_bubble_o` are constant 0, no counter flops are built, and all other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 with nonzero inputs for 2 cycles -> all outputs 0, `pc_src_mem`=0.
- Load: `valid_ex`=1, `alu_ex`=0x0000_1234, `rs2_ex`=0xDEAD_BEEF, `rd_ex`=5, `reg_write_ex`=1 -> next cycle same values on `*_mem`, `valid_mem`=1, `perf_retired_o`=1.
- Branch taken: `branch_ex`=1, `zero_ex`=1, `pc_target_ex`=0x0000_0040 -> next cycle `pc_src_mem`=1, `pc_target_mem`=0x40. Repeat with `zero_ex`=0 -> `pc_src_mem`=0. Repeat with `jump_ex`=1, `zero_ex`=0 -> `pc_src_mem`=1.
- Stall: load `alu_ex`=0xA, then `stall_i`=1 for 3 cycles while `alu_ex`=0xB -> `alu_mem` stays 0xA and counters are unchanged; release -> `alu_mem`=0xB.
- Flush vs stall: `stall_i`=1 and `flush_i`=1 with `valid_ex`=1, `mem_write_ex`=1 -> `valid_mem`=0, `mem_write_mem`=0, all data fields 0, `perf_bubble_o` incremented by 1.
- Invalid input: `valid_ex`=0 with `reg_write_ex`=1 and `jump_ex`=1 -> `reg_write_mem`=0, `pc_src_mem`=0. With `EXMEM_PERF_CNT_EN` undefined, both perf outputs read 0 throughout.
